// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall sequencer of the 5-stage MIPS core.
//  - REG_W_DEF : default register-index width
//  - need_t    : stall-need encoding produced by hazard detection
//  - OP_*      : opcode constants used upstream to derive id_uses_rt / id_branch
package hazard_stall_ctrl_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_ONE  = 2'd1,
        NEED_TWO  = 2'd2
    } need_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/hazard_stall_ctrl_detect.sv
// Purely combinational hazard classifier.
// Ports:
//  id_rs, id_rt, id_uses_rt, id_branch : ID-stage operand usage
//  ex_regwrite, ex_memread, ex_rd      : EX-stage writer
//  mem_memread, mem_rd                 : MEM-stage load
//  need                                : number of stall cycles required (0..2)
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    output need_t            need
);

    logic match_ex_s;
    logic match_mem_s;

    // A producer register matches when it is non-zero and read by the ID instruction.
    function automatic logic reg_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt,
                                       input logic             uses_rt);
        return (r != {REG_W{1'b0}}) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign match_ex_s  = reg_match(ex_rd,  id_rs, id_rt, id_uses_rt);
    assign match_mem_s = reg_match(mem_rd, id_rs, id_rt, id_uses_rt);

    // Priority chain picks the largest applicable need; branch-after-load-in-EX is the only 2.
    always_comb begin
        need = NEED_NONE;
        if (id_branch && ex_memread && match_ex_s) begin
            need = NEED_TWO;
        end else if (ex_memread && match_ex_s) begin
            need = NEED_ONE;
        end else if (id_branch && ex_regwrite && match_ex_s) begin
            need = NEED_ONE;
        end else if (id_branch && mem_memread && match_mem_s) begin
            need = NEED_ONE;
        end else begin
            need = NEED_NONE;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer: decides whether PC and IF/ID advance, hold or flush, and
// whether ID/EX takes a bubble. Keeps saturating stall and flush counters.
// Ports:
//  clk, rst_n                  : clock, asynchronous active-low reset
//  id_*, ex_*, mem_*           : hazard inputs (see hazard_detect)
//  pc_write, ifid_write        : 1 = register loads
//  ifid_flush                  : 1 = IF/ID loads a nop (taken branch)
//  idex_bubble                 : 1 = ID/EX control fields forced to 0
//  stall_cnt, flush_cnt        : saturating performance counters
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_br_taken,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    need_t            need_s;
    logic [1:0]       stall_left_r;
    logic             run_s;
    logic             stalling_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_branch   (id_branch),
        .ex_regwrite (ex_regwrite),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .mem_memread (mem_memread),
        .mem_rd      (mem_rd),
        .need        (need_s)
    );

    // Hazards are only evaluated in RUN; an ongoing stall ignores its inputs.
    assign run_s      = (stall_left_r == 2'd0);
    assign stalling_s = !run_s || (need_s != NEED_NONE);

    // Remaining-stall down-counter; the detection cycle itself counts as the first stall cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_left_r <= 2'd0;
        end else if (!run_s) begin
            stall_left_r <= stall_left_r - 2'd1;
        end else if (need_s != NEED_NONE) begin
            stall_left_r <= 2'(need_s) - 2'd1;
        end else begin
            stall_left_r <= 2'd0;
        end
    end

    // Output decode: reset forces a held pipeline, stall beats flush, flush only on a free cycle.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else if (stalling_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_branch && id_br_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b0;
        end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    // Saturating performance counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stalling_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rd = 5'd0, mem_rd = 5'd0;
    logic       id_uses_rt = 1'b0, id_branch = 1'b0, id_br_taken = 1'b0;
    logic       ex_regwrite = 1'b0, ex_memread = 1'b0, mem_memread = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_rem = 0;
    int m_sc  = 0;
    int m_fc  = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_br_taken(id_br_taken), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_stall_ctrl #(.REG_W(5), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .id_br_taken(id_br_taken), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && (r == id_rs || (id_uses_rt && r == id_rt));
    endfunction

    // Stall length the current ID/EX/MEM situation calls for: the largest applicable rule.
    function automatic int model_need();
        int n = 0;
        if (ex_memread && reads(ex_rd)) n = (n > 1) ? n : 1;
        if (id_branch && ex_regwrite && !ex_memread && reads(ex_rd)) n = (n > 1) ? n : 1;
        if (id_branch && ex_memread && reads(ex_rd)) n = 2;
        if (id_branch && mem_memread && reads(mem_rd)) n = (n > 1) ? n : 1;
        return n;
    endfunction

    // Compare process: checks both DUTs against the model each negedge, then advances the model.
    always @(negedge clk) begin
        int  nd;
        bit  stl, fl;
        if (!rst_n) begin
            m_rem = 0; m_sc = 0; m_fc = 0;
            chk("rst_pc_write", pc_write, 0);
            chk("rst_ifid_write", ifid_write, 0);
            chk("rst_ifid_flush", ifid_flush, 0);
            chk("rst_idex_bubble", idex_bubble, 1);
            chk("rst_stall_cnt", stall_cnt, 0);
            chk("rst_flush_cnt", flush_cnt, 0);
            chk("rst_small_pc_write", s_pc_write, 0);
        end else begin
            nd  = (m_rem == 0) ? model_need() : 0;
            stl = (m_rem != 0) || (nd != 0);
            fl  = !stl && id_branch && id_br_taken;
            chk("pc_write", pc_write, !stl);
            chk("ifid_write", ifid_write, !stl);
            chk("ifid_flush", ifid_flush, fl);
            chk("idex_bubble", idex_bubble, stl);
            chk("stall_cnt", stall_cnt, (m_sc > 65535) ? 65535 : m_sc);
            chk("flush_cnt", flush_cnt, (m_fc > 65535) ? 65535 : m_fc);
            chk("small_pc_write", s_pc_write, !stl);
            chk("small_ifid_flush", s_ifid_flush, fl);
            chk("small_stall_cnt", s_stall_cnt, (m_sc > 3) ? 3 : m_sc);
            chk("small_flush_cnt", s_flush_cnt, (m_fc > 3) ? 3 : m_fc);
            if (m_rem != 0) m_rem = m_rem - 1;
            else if (nd != 0) m_rem = nd - 1;
            if (stl) m_sc++;
            if (fl) m_fc++;
        end
    end

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0; id_br_taken = 1'b0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0; mem_memread = 1'b0; mem_rd = 5'd0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        idle();
        repeat (cycles) next();
        rst_n = 1'b1;
    endtask

    task automatic lw_beq();
        idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8;
        id_branch = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b1; id_rs = 5'd3;
    endtask

    initial begin
        // 1: reset held 3 cycles
        idle();
        rst_n = 1'b0;
        repeat (3) next();
        #1;
        chk("t1_pc_write_in_reset", pc_write, 0);
        chk("t1_bubble_in_reset", idex_bubble, 1);
        chk("t1_stall_cnt_in_reset", stall_cnt, 0);
        rst_n = 1'b1;
        next(); #1;
        chk("t1_pc_write_after_release", pc_write, 1);

        // 2: load-use -> one stall cycle
        do_reset(2);
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        #1;
        chk("t2_stall_pc_write", pc_write, 0);
        next(); idle(); #1;
        chk("t2_resume_pc_write", pc_write, 1);
        chk("t2_stall_cnt", stall_cnt, 1);

        // 3: lw then beq -> two stalls, then flush
        do_reset(2);
        lw_beq(); #1;
        chk("t3_stall1", pc_write, 0);
        next(); #1;
        chk("t3_stall2", pc_write, 0);
        chk("t3_no_flush_while_stalled", ifid_flush, 0);
        next();
        idle(); id_branch = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b1; id_br_taken = 1'b1; #1;
        chk("t3_flush", ifid_flush, 1);
        chk("t3_flush_pc_write", pc_write, 1);
        next(); idle(); #1;
        chk("t3_flush_one_cycle", ifid_flush, 0);
        chk("t3_stall_cnt", stall_cnt, 2);
        chk("t3_flush_cnt", flush_cnt, 1);

        // 4: register 0 and unused rt never stall
        idle(); ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; #1;
        chk("t4_reg0", pc_write, 1);
        next();
        idle(); ex_memread = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
        chk("t4_unused_rt", pc_write, 1);
        next();

        // 5: reset mid-stall
        do_reset(2);
        lw_beq();
        next();
        rst_n = 1'b0; #1;
        chk("t5_pc_write", pc_write, 0);
        chk("t5_ifid_write", ifid_write, 0);
        chk("t5_bubble", idex_bubble, 1);
        next(); idle(); rst_n = 1'b1;
        next(); #1;
        chk("t5_no_residual", pc_write, 1);

        // 6: five stall cycles saturate the 2-bit counter
        do_reset(2);
        ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        repeat (5) next();
        idle(); #1;
        chk("t6_small_sat", s_stall_cnt, 3);
        chk("t6_wide", stall_cnt, 5);

        // randomized traffic with small register space to provoke hits
        for (int i = 0; i < 4000; i++) begin
            next();
            rst_n       = ($urandom_range(0, 199) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom);
            id_branch   = ($urandom_range(0, 2) == 0);
            id_br_taken = 1'($urandom);
            ex_regwrite = 1'($urandom);
            ex_memread  = ($urandom_range(0, 2) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            mem_memread = ($urandom_range(0, 2) == 0);
            mem_rd      = 5'($urandom_range(0, 3));
        end
        next();
        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
